game_referee: RTL
=================

// Module: game_referee
// PURPOSE
//  Downstream stage of counter_main: tallies its winner/loser pulses, declares the game outcome
//  when a tally reaches its limit, and re-arms counter_main through an init/load restart sequence.
//  Replaces the per-outcome counter_4 instances plus bench-side "who" decode and reset with one
//  synthesizable referee. Outcome is held until a consumer acknowledges it.
// PARAMETERS
//  TALLY_W     4      width of each tally counter
//  WIN_LIMIT   15     winner pulses that end a game (1..2**TALLY_W-1)
//  LOSE_LIMIT  15     loser pulses that end a game (1..2**TALLY_W-1)
//  HOLD_CYCLES 2      cycles restart_init is held high (>=1)
//  SEED        8'h0F  value driven on restart_load during restart
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-low reset
//  winner        in   1        one-cycle pulse from counter_main
//  loser         in   1        one-cycle pulse from counter_main
//  start         in   1        leave IDLE and begin a game
//  ack           in   1        consumer has taken the declared result
//  win_tally     out  TALLY_W  current winner count
//  lose_tally    out  TALLY_W  current loser count
//  who           out  2        00 none, 01 win, 10 lose, 11 tie
//  result_valid  out  1        who is valid, held until ack
//  restart_init  out  1        init strobe to counter_main
//  restart_load  out  8        load value to counter_main (SEED while restart_init, else 0)
// BEHAVIOUR
//  - Reset (reset==0, async assert, sync release): state IDLE; all outputs 0.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM: IDLE -start-> PLAY -limit hit-> DECLARE -ack-> RELOAD -HOLD_CYCLES done-> PLAY.
//  - IDLE: tallies 0; winner/loser/ack ignored; start=1 -> PLAY next edge.
//  - PLAY: each winner pulse +1 win_tally, each loser pulse +1 lose_tally; both may count same edge.
//    If after the update win_tally==WIN_LIMIT or lose_tally==LOSE_LIMIT, state->DECLARE on that
//    same edge: result_valid=1 and who=01 (win only), 10 (lose only), 11 (both on same edge).
//    Tallies never exceed their limits (pulse that would overshoot cannot occur: FSM leaves PLAY).
//  - DECLARE: tallies and who frozen; winner/loser ignored; start ignored. ack=1 -> RELOAD next
//    edge, result_valid/who cleared on that edge. ack seen any other state is ignored.
//  - RELOAD: tallies cleared on entry; restart_init=1, restart_load=SEED for exactly HOLD_CYCLES
//    cycles; pulses ignored; then PLAY with restart_init=0, restart_load=0.
//  - start asserted outside IDLE has no effect. Only reset returns FSM to IDLE.
//  - Reset mid-game (any state): immediate clear, no result emitted, restart_init drops at once.
//  - Latency: limit-reaching pulse sampled at edge N -> result_valid high after edge N;
//    ack sampled at edge M -> restart_init high from M to M+HOLD_CYCLES.
// TESTING
//  1. Reset then start, 15 winner pulses, 0 loser -> after 15th edge win_tally=15,
//     who=01, result_valid=1, held while ack=0 for 20 cycles.
//  2. From state of 1, ack=1 one cycle -> next edge result_valid=0, who=00,
//     tallies=0; restart_init=1, restart_load=8'h0F for 2 cycles, then 0; winner pulse counts again.
//  3. 14 winner + 14 loser pulses, then winner&loser same cycle -> who=11, both tallies=15.
//  4. 15 loser pulses interleaved with 7 winner pulses -> who=10, win_tally=7 frozen;
//     extra winner pulses in DECLARE leave win_tally=7.
//  5. Reset dropped low mid-RELOAD (restart_init=1) -> all outputs 0 immediately,
//     state IDLE; pulses ignored until start.
//  6. Pulses and ack while in IDLE, start while in PLAY -> no tally change, no state change.

Source files
------------

// File: rtl/game_referee.sv
// rtl/game_referee.sv - tallies counter_main outcome pulses, declares a result, re-arms counter_main
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   winner/loser  one-cycle outcome pulses from counter_main
//   start         leave IDLE and begin the first game
//   ack           consumer has taken the declared result
//   win_tally     current winner count
//   lose_tally    current loser count
//   who           00 none, 01 win, 10 lose, 11 tie
//   result_valid  who is valid; held until ack
//   restart_init  init strobe to counter_main, high for HOLD_CYCLES after ack
//   restart_load  SEED while restart_init is high, else 0
module game_referee #(
  parameter int         TALLY_W     = 4,
  parameter int         WIN_LIMIT   = 15,
  parameter int         LOSE_LIMIT  = 15,
  parameter int         HOLD_CYCLES = 2,
  parameter logic [7:0] SEED        = 8'h0F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               winner,
  input  logic               loser,
  input  logic               start,
  input  logic               ack,
  output logic [TALLY_W-1:0] win_tally,
  output logic [TALLY_W-1:0] lose_tally,
  output logic [1:0]         who,
  output logic               result_valid,
  output logic               restart_init,
  output logic [7:0]         restart_load
);

  typedef enum logic [1:0] {IDLE, PLAY, DECLARE, RELOAD} state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t              state, state_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [TALLY_W-1:0]  win_nx, lose_nx;
  logic [1:0]          who_nx;
  logic                valid_nx, init_nx;
  logic [7:0]          load_nx;

  // Tallies as they would be after counting this cycle's pulses.
  logic [TALLY_W-1:0]  win_sum, lose_sum;
  logic                hit_w, hit_l;

  assign win_sum  = win_tally + TALLY_W'(winner);
  assign lose_sum = lose_tally + TALLY_W'(loser);
  assign hit_w    = (win_sum == TALLY_W'(WIN_LIMIT));
  assign hit_l    = (lose_sum == TALLY_W'(LOSE_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      win_tally    <= '0;
      lose_tally   <= '0;
      who          <= 2'b00;
      result_valid <= 1'b0;
      restart_init <= 1'b0;
      restart_load <= 8'h00;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_nx;
      win_tally    <= win_nx;
      lose_tally   <= lose_nx;
      who          <= who_nx;
      result_valid <= valid_nx;
      restart_init <= init_nx;
      restart_load <= load_nx;
    end
  end

  // Every output is computed here as its next registered value, so nothing
  // reaches an output port without passing through a flop.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    win_nx   = win_tally;
    lose_nx  = lose_tally;
    who_nx   = who;
    valid_nx = result_valid;
    init_nx  = restart_init;
    load_nx  = restart_load;
    case (state)
      IDLE: begin
        win_nx  = '0;
        lose_nx = '0;
        if (start) state_nx = PLAY;
      end
      PLAY: begin
        win_nx  = win_sum;
        lose_nx = lose_sum;
        if (hit_w || hit_l) begin
          state_nx = DECLARE;
          valid_nx = 1'b1;
          who_nx   = {hit_l, hit_w};
        end
      end
      DECLARE: begin
        if (ack) begin
          state_nx = RELOAD;
          valid_nx = 1'b0;
          who_nx   = 2'b00;
          win_nx   = '0;
          lose_nx  = '0;
          init_nx  = 1'b1;
          load_nx  = SEED;
          hold_nx  = '0;
        end
      end
      RELOAD: begin
        // restart_init went high on the ack edge; the count covers the
        // remaining HOLD_CYCLES-1 edges before dropping it.
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nx = PLAY;
          init_nx  = 1'b0;
          load_nx  = 8'h00;
          hold_nx  = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
